// File: rtl/msg_sched_if.sv
// Schedule-word stream from msg_sched to the compression stage.
// Valid/ready: a word transfers on a rising clk edge where wValid & wReady are both 1.
// While wValid=1 and wReady=0, the producer holds wOut and wIndex stable.
interface msg_sched_if;
  logic [31:0] wOut;
  logic [5:0]  wIndex;
  logic        wValid;
  logic        wReady;

  modport master (output wOut, output wIndex, output wValid, input wReady);
  modport slave  (input wOut, input wIndex, input wValid, output wReady);
endinterface

// File: rtl/msg_sched.sv
// SHA-256 message scheduler: loads one padded 64-byte block from memory and
// streams W[0..63], expanding W[16..63] through a 16-entry circular buffer.
module msg_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BLOCK_SIZE = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] memAddrLine,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memDataLine,
  msg_sched_if.master           w,
  output logic                  finish,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2, DONE = 2'd3} state_e;

  localparam int            CW       = $clog2(BLOCK_SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_SIZE);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mem_read_q, mem_read_d;
  logic [31:0]           w_out_q, w_out_d;
  logic [5:0]            w_index_q, w_index_d;
  logic                  w_valid_q, w_valid_d;
  logic                  finish_q, finish_d;
  logic [31:0]           sched_q [16];
  logic [31:0]           sched_d [16];

  logic [5:0]  byte_idx;
  logic [5:0]  n_idx;
  logic [3:0]  n_slot;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Byte captured this cycle was addressed one cycle earlier.
  assign byte_idx = 6'(cnt_q - CW'(1));

  // Slots for W[n-2], W[n-7], W[n-15], W[n-16] modulo 16; none is the slot written this cycle.
  assign n_idx  = w_index_q + 6'd1;
  assign n_slot = n_idx[3:0];
  assign w_next = (n_idx < 6'd16) ? sched_q[n_slot]
                : sig1(sched_q[n_slot - 4'd2]) + sched_q[n_slot - 4'd7]
                  + sig0(sched_q[n_slot + 4'd1]) + sched_q[n_slot];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mem_read_d = mem_read_q;
    w_out_d    = w_out_q;
    w_index_d  = w_index_q;
    w_valid_d  = w_valid_q;
    finish_d   = finish_q;
    sched_d    = sched_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          cnt_d      = '0;
          addr_d     = ADDR_WIDTH'(BASE_ADDR);
          mem_read_d = 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q != '0) begin
          sched_d[byte_idx[5:2]][8*(3 - int'(byte_idx[1:0])) +: 8] = memDataLine[7:0];
        end
        if (cnt_q == LAST_CNT) begin
          state_d   = EXPAND;
          w_valid_d = 1'b1;
          w_index_d = 6'd0;
          w_out_d   = sched_q[0];
        end else begin
          cnt_d      = cnt_q + CW'(1);
          addr_d     = addr_q + ADDR_WIDTH'(1);
          mem_read_d = (cnt_d != LAST_CNT);
        end
      end
      EXPAND: begin
        if (w.wReady) begin
          sched_d[w_index_q[3:0]] = w_out_q;
          if (w_index_q == 6'd63) begin
            state_d   = DONE;
            w_valid_d = 1'b0;
            finish_d  = 1'b1;
          end else begin
            w_index_d = n_idx;
            w_out_d   = w_next;
          end
        end
      end
      DONE: begin
        // Held start keeps us here, so it cannot retrigger a load.
        if (!start) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_read_q <= 1'b0;
      w_out_q    <= '0;
      w_index_q  <= '0;
      w_valid_q  <= 1'b0;
      finish_q   <= 1'b0;
      sched_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mem_read_q <= mem_read_d;
      w_out_q    <= w_out_d;
      w_index_q  <= w_index_d;
      w_valid_q  <= w_valid_d;
      finish_q   <= finish_d;
      sched_q    <= sched_d;
    end
  end

  assign memRead     = mem_read_q;
  assign memAddrLine = mem_read_q ? addr_q : {ADDR_WIDTH{1'bz}};
  assign w.wOut      = w_out_q;
  assign w.wIndex    = w_index_q;
  assign w.wValid    = w_valid_q;
  assign finish      = finish_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_msg_sched.sv
// Bench for msg_sched: memory model, scoreboard of expected schedule words,
// directed runs for empty/"abc"/pattern blocks, backpressure, held start and reset abort.
module tb_msg_sched;
  localparam int AW   = 10;
  localparam int BASE = 'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          w_ready = 1'b0;
  wire  [AW-1:0] mem_addr;
  logic          mem_read;
  logic [7:0]    mem_data = 8'h00;
  logic          finish;
  logic [1:0]    dbg_state;

  msg_sched_if wif();
  assign wif.wReady = w_ready;

  msg_sched #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(64),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .memAddrLine(mem_addr),
    .memRead    (mem_read),
    .memDataLine(mem_data),
    .w          (wif),
    .finish     (finish),
    .dbg_state  (dbg_state)
  );

  // Clock and memory with one-cycle read latency
  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) if (mem_read) mem_data <= mem[mem_addr];

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  int          bus_cnt = 0;
  logic [37:0] exp_q[$];
  logic [31:0] model_w [64];
  logic [31:0] got_w [64];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++)
      model_w[t] = {mem[BASE+4*t], mem[BASE+4*t+1], mem[BASE+4*t+2], mem[BASE+4*t+3]};
    for (int t = 16; t < 64; t++)
      model_w[t] = (rotr(model_w[t-2], 17) ^ rotr(model_w[t-2], 19) ^ (model_w[t-2] >> 10))
                 + model_w[t-7]
                 + (rotr(model_w[t-15], 7) ^ rotr(model_w[t-15], 18) ^ (model_w[t-15] >> 3))
                 + model_w[t-16];
  endtask

  task automatic fill_block(input int kind);
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       b = (i == 0) ? 8'h80 : 8'h00;
        1: begin
          case (i)
            0: b = 8'h61;  1: b = 8'h62;  2: b = 8'h63;  3: b = 8'h80;
            63: b = 8'h18;
            default: b = 8'h00;
          endcase
        end
        default: b = 8'(i * 37 + 5);
      endcase
      mem[BASE+i] = b;
    end
  endtask

  // Driver: model the block, queue the expected words, raise start
  task automatic issue_start();
    build_model();
    exp_q.delete();
    for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), model_w[t]});
    bus_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while (finish !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, finish}, 32'd1);
  endtask

  task automatic end_of_run(input string tag);
    check({tag, "_exp_q_drained"}, exp_q.size(), 32'd0);
    check({tag, "_bus_cycles"}, bus_cnt, 32'd64);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks bus addresses
  initial begin : monitor
    logic [37:0] e;
    logic        fin_pending;
    fin_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (fin_pending) begin
          check("finish_after_w63", {31'd0, finish}, 32'd1);
          check("wvalid_low_after_w63", {31'd0, wif.wValid}, 32'd0);
          fin_pending = 1'b0;
        end
        if (wif.wValid && wif.wReady) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got index %0d, expected no transfer", wif.wIndex);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("w_index[%0d]", e[37:32]), {26'd0, wif.wIndex}, {26'd0, e[37:32]});
            check($sformatf("w_out[%0d]", e[37:32]), wif.wOut, e[31:0]);
            got_w[wif.wIndex] = wif.wOut;
            if (wif.wIndex == 6'd63) fin_pending = 1'b1;
          end
        end
        if (mem_read) begin
          check($sformatf("mem_addr[%0d]", bus_cnt), {22'd0, mem_addr}, 32'(BASE + bus_cnt));
          bus_cnt++;
        end
      end else begin
        fin_pending = 1'b0;
      end
    end
  end

  // Stimulus sequence
  initial begin : stim
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_wvalid", {31'd0, wif.wValid}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_windex", {26'd0, wif.wIndex}, 32'd0);
    check("rst_wout", wif.wOut, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Empty message, full throughput, start held throughout
    fill_block(0);
    w_ready = 1'b1;
    issue_start();
    wait_finish("a_finish");
    repeat (8) begin
      @(negedge clk);
      check("a_held_start_no_load", {31'd0, mem_read}, 32'd0);
      check("a_held_start_finish", {31'd0, finish}, 32'd1);
    end
    end_of_run("a");
    check("a_w0", got_w[0], 32'h80000000);
    check("a_w1", got_w[1], 32'h00000000);
    check("a_w15", got_w[15], 32'h00000000);
    check("a_w16", got_w[16], 32'h80000000);
    check("a_w17", got_w[17], 32'h00000000);
    check("a_w18", got_w[18], 32'h00205000);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("a_finish_clear", {31'd0, finish}, 32'd0);
    check("a_back_to_idle", {30'd0, dbg_state}, 32'd0);

    // "abc" block with a 5-cycle stall at W20 and a start pulse during EXPAND
    fill_block(1);
    issue_start();
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(wif.wValid && wif.wIndex == 6'd20) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_reach_w20", {26'd0, wif.wIndex}, 32'd20);
    w_ready = 1'b0;
    start = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("b_stall_index", {26'd0, wif.wIndex}, 32'd20);
      check("b_stall_wout", wif.wOut, model_w[20]);
      check("b_stall_valid", {31'd0, wif.wValid}, 32'd1);
    end
    w_ready = 1'b1;
    @(posedge clk); #1;
    check("b_after_stall_index", {26'd0, wif.wIndex}, 32'd21);
    wait_finish("b_finish");
    @(negedge clk);
    end_of_run("b");
    check("b_w0", got_w[0], 32'h61626380);
    check("b_w15", got_w[15], 32'h00000018);
    check("b_w16", got_w[16], 32'h61626380);
    check("b_w17", got_w[17], 32'h000F0000);

    // Pattern block: reset at byte 30 of LOAD, then a clean reload with uneven wReady
    fill_block(2);
    issue_start();
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem_read && mem_addr == AW'(BASE + 30)) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("c_reach_addr30", {22'd0, mem_addr}, 32'(BASE + 30));
    rst = 1'b0;
    @(posedge clk); #1;
    check("c_abort_state", {30'd0, dbg_state}, 32'd0);
    check("c_abort_mem_read", {31'd0, mem_read}, 32'd0);
    check("c_abort_wvalid", {31'd0, wif.wValid}, 32'd0);
    check("c_abort_finish", {31'd0, finish}, 32'd0);
    check("c_abort_windex", {26'd0, wif.wIndex}, 32'd0);
    check("c_abort_wout", wif.wOut, 32'd0);
    rst = 1'b1;
    issue_start();
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (finish !== 1'b1 && n < 600) begin
      @(posedge clk); #1;
      w_ready = (n % 3 != 1);
      n++;
    end
    check("c_finish", {31'd0, finish}, 32'd1);
    @(negedge clk);
    end_of_run("c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of sequence, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, memory byte width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 64, bytes per padded 512-bit block.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, memory address of block byte 0.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset; synchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit, begin load; driven by the padding stage's finish.
REQ-008 The block SHALL have port memAddrLine, output, ADDR_WIDTH bits, read address; high-Z when memRead=0.
REQ-009 The block SHALL have port memRead, output, 1 bit, read strobe; 1 while this block owns the bus.
REQ-010 The block SHALL have port memDataLine, input, DATA_WIDTH bits, read data, valid 1 cycle after address/memRead.
REQ-011 The block SHALL have port wOut, output, 32 bits, schedule word W[t].
REQ-012 The block SHALL have port wIndex, output, 6 bits, t of the word on wOut.
REQ-013 The block SHALL have port wValid, output, 1 bit, wOut/wIndex valid.
REQ-014 The block SHALL have port wReady, input, 1 bit, consumer accepts; transfer = wValid & wReady on a clock edge.
REQ-015 The block SHALL have port finish, output, 1 bit, all 64 words transferred.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD, EXPAND, DONE.
REQ-017 IDLE -> LOAD SHALL occur on start=1; start SHALL be ignored in LOAD and EXPAND.
REQ-018 In LOAD, the block SHALL drive memRead=1 and memAddrLine=BASE_ADDR+i for i=0..63, one per cycle, consecutive.
REQ-019 Byte i captured from memDataLine the cycle after its address SHALL go to word i/4, bits [31-8*(i%4) : 24-8*(i%4)] (big-endian).
REQ-020 LOAD SHALL last 65 cycles (64 issue + final capture); memRead SHALL drop after address 63; then -> EXPAND.
REQ-021 The 16 loaded words SHALL be held in a 16x32 circular buffer, slot = t mod 16.
REQ-022 In EXPAND, wValid SHALL be 1 starting the first EXPAND cycle, with wIndex=t starting at 0.
REQ-023 For t<16, wOut SHALL equal buf[t].
REQ-024 For t>=16, wOut SHALL equal s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32, carries discarded.
REQ-025 s0(x) SHALL equal ROTR7^ROTR18^SHR3; s1(x) SHALL equal ROTR17^ROTR19^SHR10.
REQ-026 On transfer at t>=16, the block SHALL write wOut into buf[t mod 16]; t SHALL increment.
REQ-027 While wValid=1 & wReady=0, wOut and wIndex SHALL be held stable; no word SHALL be skipped or duplicated.
REQ-028 Max throughput SHALL be one word per cycle with wReady held 1.
REQ-029 On transfer of t=63, wValid SHALL go 0 next cycle, state -> DONE, finish=1.
REQ-030 DONE SHALL hold finish=1 while start=1; start=0 SHALL give -> IDLE, finish=0 next cycle.
REQ-031 A new start SHALL be accepted only from IDLE, so a held start after finish SHALL NOT re-trigger.

Reset
REQ-032 On rst=0 at a clock edge, the block SHALL force state=IDLE, t=0, byte counter=0, memRead=0, wValid=0, finish=0, wIndex=0, wOut=0.
REQ-033 While memRead=0, including reset, memAddrLine SHALL be high-Z.
REQ-034 Reset mid-LOAD or mid-EXPAND SHALL abort; buffer contents are don't-care; the next start SHALL reload from byte 0.

Verification
REQ-035 Empty-message block (byte0=0x80, bytes1..63=0x00), wReady=1 -> W0=0x80000000, W1..W15=0, W16=0x80000000, W17=0x00000000, W18=0x00205000; finish 1 cycle after W63.
REQ-036 "abc" block (61 62 63 80, zeros, byte63=0x18) -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; all 64 words match a software model.
REQ-037 Backpressure: wReady=0 for 5 cycles while wIndex=20 -> wOut/wIndex constant, then W20 transfers once, wIndex=21 next.
REQ-038 Bus timing: memRead=1 exactly 64 cycles with addresses BASE_ADDR..BASE_ADDR+63 in order; memAddrLine Z otherwise; BASE_ADDR=0x100 gives 0x100..0x13F.
REQ-039 rst=0 during LOAD at byte 30 -> all outputs 0/Z next cycle; new start -> addresses restart at BASE_ADDR, correct words.
REQ-040 Start held after finish -> no second LOAD; start pulse during EXPAND ignored; start 0 then 1 -> new LOAD.
